// File: rtl/bit_serializer.sv
// LSB-first parallel-to-serial converter with valid/ready input and gapless reload.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity trailer bit to every word.
module bit_serializer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);

`ifdef BIT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t            state, state_n;
    logic [WIDTH-1:0]  shreg, shreg_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              x_n, x_valid_n, done_n, busy_n;
    logic              last, accept;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic              par, par_n;
`endif

    assign last = (cnt == CW'(WIDTH));

    // Ready is combinational from state; held low while reset is asserted.
    always_comb begin
        din_ready = 1'b0;
        case (state)
            IDLE:   din_ready = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            PARITY: din_ready = 1'b1;
            SHIFT:  din_ready = 1'b0;
`else
            SHIFT:  din_ready = last;
`endif
            default: din_ready = 1'b0;
        endcase
        din_ready = din_ready & rst_n;
    end

    assign accept = din_valid & din_ready;

    always_comb begin
        // Default: fall back to IDLE with a quiet line.
        state_n   = IDLE;
        shreg_n   = shreg;
        cnt_n     = '0;
        x_n       = 1'b0;
        x_valid_n = 1'b0;
        done_n    = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_n     = par;
`endif
        if (state == SHIFT && !last) begin
            state_n   = SHIFT;
            shreg_n   = shreg >> 1;
            x_n       = shreg[1];
            x_valid_n = 1'b1;
            cnt_n     = cnt + CW'(1);
`ifndef BIT_SERIALIZER_PARITY_EN
            done_n    = ((cnt + CW'(1)) == CW'(WIDTH));
`endif
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        else if (state == SHIFT) begin
            state_n   = PARITY;
            x_n       = par;
            x_valid_n = 1'b1;
            done_n    = 1'b1;
        end
`endif
        else if (accept) begin
            // First bit is registered on the accept edge itself.
            state_n   = SHIFT;
            shreg_n   = din;
            x_n       = din[0];
            x_valid_n = 1'b1;
            cnt_n     = CW'(1);
`ifdef BIT_SERIALIZER_PARITY_EN
            par_n     = ^din;
`endif
        end
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            cnt     <= cnt_n;
            x       <= x_n;
            x_valid <= x_valid_n;
            busy    <= busy_n;
            done    <= done_n;
`ifdef BIT_SERIALIZER_PARITY_EN
            par     <= par_n;
`endif
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer (WIDTH=6); follows BIT_SERIALIZER_PARITY_EN if defined.
module tb_bit_serializer;
    localparam int W = 6;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int SYM = W + 1;
`else
    localparam int SYM = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready, x, x_valid, busy, done;
    int           checks = 0;
    int           errors = 0;
    int           accepts;
    logic [W-1:0] latched;

    bit_serializer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .x(x), .x_valid(x_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Symbol k of a word: data bits LSB-first, then the even-parity trailer.
    function automatic logic sym(input logic [W-1:0] w, input int k);
        return (k < W) ? w[k] : ^w;
    endfunction

    // Checks one full word on the line, starting in the cycle after its accept edge.
    task automatic expect_word(input logic [W-1:0] w, input string tag);
        for (int k = 0; k < SYM; k++) begin
            chk({tag, "_x"}, x, sym(w, k));
            chk({tag, "_xv"}, x_valid, 1);
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_done"}, done, (k == SYM - 1));
            chk({tag, "_rdy"}, din_ready, (k == SYM - 1));
            tick();
        end
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_xv"}, x_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rdy"}, din_ready, 1);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_x", x, 0);
        chk("rst_xv", x_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdy", din_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy", din_ready, 1);

        // Idle hold
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_idle("idle");
        end

        // Single word
        din = 6'b101101; din_valid = 1'b1;
        tick();
        din_valid = 1'b0; din = 6'b010010;
        expect_word(6'b101101, "single");
        expect_idle("single_end");

        // Back-to-back under continuous valid
        accepts = 0;
        din = 6'b000001; din_valid = 1'b1;
        if (din_ready) accepts++;
        tick();
        din = 6'b111110;
        for (int i = 0; i < 2 * SYM; i++) begin
            chk("b2b_x", x, (i < SYM) ? sym(6'b000001, i) : sym(6'b111110, i - SYM));
            chk("b2b_xv", x_valid, 1);
            if (din_valid && din_ready) accepts++;
            tick();
            if (i == SYM - 1) din_valid = 1'b0;
        end
        chk("b2b_accepts", accepts, 2);
        expect_idle("b2b_end");

        // Backpressure: valid raised mid-word with a changing din
        din = 6'b010011; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        latched = '0;
        for (int i = 0; i < SYM; i++) begin
            chk("bp_x", x, sym(6'b010011, i));
            chk("bp_xv", x_valid, 1);
            if (i >= 2) begin
                din_valid = 1'b1;
                din = (i % 2 == 1) ? 6'h2A : 6'h15;
                latched = din;
            end
            tick();
        end
        din_valid = 1'b0; din = 6'h3F;
        expect_word(latched, "bp_new");
        expect_idle("bp_end");

        // Asynchronous reset mid-word
        din = 6'b111111; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("mid_x_before", x, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_x", x, 0);
        chk("arst_xv", x_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_rdy", din_ready, 0);
        tick();
        #1 rst_n = 1'b1;
        #1;
        expect_idle("arst_rel");
        din = 6'b000110; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        expect_word(6'b000110, "post_rst");
        expect_idle("post_rst_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
